// File: rtl/qu_common.sv
// rtl/qu_common.sv - shared Qu types: reservation-station cell, tag width, CDB capture helper
package qu_common;

   localparam int QU_TAG_WIDTH = 5;
   localparam int QU_RS_DEPTH  = 8;
   localparam logic [QU_TAG_WIDTH-1:0] QU_TAG_READY = '0;

   typedef struct packed {
      logic [7:0]              op;
      logic [31:0]             vj;
      logic [31:0]             vk;
      logic [QU_TAG_WIDTH-1:0] qj;
      logic [QU_TAG_WIDTH-1:0] qk;
      logic [31:0]             a;
      logic [31:0]             pc;
   } res_st_cell_t;

   // j and k sides match independently so one broadcast can satisfy both operands
   function automatic res_st_cell_t cdb_capture(input res_st_cell_t c,
                                                input logic hit,
                                                input logic [QU_TAG_WIDTH-1:0] tag,
                                                input logic [31:0] value);
      res_st_cell_t r;
      r = c;
      if (hit && c.qj == tag) begin
         r.vj = value;
         r.qj = QU_TAG_READY;
      end
      if (hit && c.qk == tag) begin
         r.vk = value;
         r.qk = QU_TAG_READY;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - find-first-set: lowest set bit index plus found flag
module prio_enc #(
   parameter  int N  = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = IW'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/res_station.sv
// rtl/res_station.sv - reservation station: buffers renamed ops, snoops the CDB, issues ready ops
module res_station
   import qu_common::*;
#(
   parameter  int RS_DEPTH  = QU_RS_DEPTH,
   parameter  int TAG_WIDTH = QU_TAG_WIDTH,
   localparam int IW        = $clog2(RS_DEPTH),
   localparam int OW        = $clog2(RS_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  res_st_cell_t         alloc_cell,
   input  logic                 cdb_valid,
   input  logic [TAG_WIDTH-1:0] cdb_tag,
   input  logic [31:0]          cdb_value,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output res_st_cell_t         issue_cell,
   output logic [OW-1:0]        occupancy
);

   logic [RS_DEPTH-1:0] r_busy;
   res_st_cell_t        r_cell [RS_DEPTH];
   logic                r_out_valid;
   res_st_cell_t        r_out_cell;
   logic [OW-1:0]       r_occ;

   logic [RS_DEPTH-1:0] w_ready;
   logic [IW-1:0]       w_free_idx;
   logic [IW-1:0]       w_rdy_idx;
   logic                w_free_found;
   logic                w_rdy_found;
   logic                w_cdb_hit;
   logic                w_do_alloc;
   logic                w_out_open;
   logic                w_load;
   res_st_cell_t        w_alloc_cell;

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_ready[i] = r_busy[i] && (r_cell[i].qj == QU_TAG_READY) && (r_cell[i].qk == QU_TAG_READY);
      end
   end

   prio_enc #(.N(RS_DEPTH)) u_free_enc (
      .i_req   (~r_busy),
      .o_idx   (w_free_idx),
      .o_found (w_free_found)
   );

   prio_enc #(.N(RS_DEPTH)) u_rdy_enc (
      .i_req   (w_ready),
      .o_idx   (w_rdy_idx),
      .o_found (w_rdy_found)
   );

   assign alloc_ready  = (r_occ != OW'(RS_DEPTH));
   assign w_cdb_hit    = cdb_valid && (cdb_tag != QU_TAG_READY);
   assign w_do_alloc   = alloc_valid && alloc_ready && w_free_found;
   assign w_out_open   = !r_out_valid || issue_ready;
   assign w_load       = w_out_open && w_rdy_found;
   assign w_alloc_cell = cdb_capture(alloc_cell, w_cdb_hit, cdb_tag, cdb_value);

   assign issue_valid = r_out_valid;
   assign issue_cell  = r_out_cell;
   assign occupancy   = r_occ;

   // The load source is busy and the alloc target is free, so the two indices never collide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy      <= '0;
         r_out_valid <= 1'b0;
         r_out_cell  <= '0;
         r_occ       <= '0;
      end else if (flush) begin
         r_busy      <= '0;
         r_out_valid <= 1'b0;
         r_occ       <= '0;
      end else begin
         if (w_load) r_busy[w_rdy_idx] <= 1'b0;
         if (w_do_alloc) r_busy[w_free_idx] <= 1'b1;
         if (w_out_open) begin
            r_out_valid <= w_rdy_found;
            if (w_rdy_found) r_out_cell <= r_cell[w_rdy_idx];
         end
         r_occ <= r_occ + OW'(w_do_alloc) - OW'(w_load);
      end
   end

   // Payload is qualified by r_busy, so it needs no reset or flush
   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (w_do_alloc && (w_free_idx == IW'(i))) r_cell[i] <= w_alloc_cell;
         else r_cell[i] <= cdb_capture(r_cell[i], w_cdb_hit, cdb_tag, cdb_value);
      end
   end

endmodule
